// File: rtl/pipeline_hazard_controller.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use bubbles, wrong-path
// squash on control transfers, dmem-wait freeze and saturating perf counters.
module pipeline_hazard_controller #(
    parameter int CNT_W       = 16,
    parameter int MEM_TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       IFID_rs,
    input  logic [4:0]       IFID_rt,
    input  logic             IFID_UsesRt,
    input  logic             IDEX_MemRead,
    input  logic [4:0]       IDEX_rt,
    input  logic             Branch_Taken,
    input  logic             Jump,
    input  logic             JRCtrl,
    input  logic             EXMEM_MemAccess,
    input  logic             dmem_ready,
    input  logic             cnt_clear,
    output logic             PCWrite,
    output logic             IFIDWrite,
    output logic             Mux_Select_Stall,
    output logic             IFID_Flush,
    output logic             Pipe_Freeze,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic [1:0] {RUN, LU_STALL, MEM_WAIT} state_t;

    localparam int WCW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [WCW-1:0] WAIT_LAST = WCW'(MEM_TIMEOUT - 1);

    state_t           r_state;
    state_t           w_next;
    logic [WCW-1:0]   r_wait;
    logic             r_timeout;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    logic w_lu;
    logic w_mw;
    logic w_ctrl;
    logic w_stall_inc;

    assign w_lu   = IDEX_MemRead && (IDEX_rt != 5'd0) &&
                    ((IDEX_rt == IFID_rs) || (IFID_UsesRt && (IDEX_rt == IFID_rt)));
    assign w_mw   = EXMEM_MemAccess && !dmem_ready;
    assign w_ctrl = Branch_Taken || Jump || JRCtrl;

    always_comb begin
        w_next           = r_state;
        PCWrite          = 1'b1;
        IFIDWrite        = 1'b1;
        Mux_Select_Stall = 1'b0;
        IFID_Flush       = 1'b0;
        Pipe_Freeze      = 1'b0;
        case (r_state)
            RUN: begin
                if (w_mw) begin
                    Pipe_Freeze = 1'b1;
                    PCWrite     = 1'b0;
                    IFIDWrite   = 1'b0;
                    w_next      = MEM_WAIT;
                end else if (w_lu) begin
                    // The stalled instruction re-decodes next cycle, so a
                    // concurrent control transfer must not squash it now.
                    PCWrite          = 1'b0;
                    IFIDWrite        = 1'b0;
                    Mux_Select_Stall = 1'b1;
                    w_next           = LU_STALL;
                end else if (w_ctrl) begin
                    IFID_Flush = 1'b1;
                end
            end
            LU_STALL: begin
                if (w_mw) begin
                    Pipe_Freeze = 1'b1;
                    PCWrite     = 1'b0;
                    IFIDWrite   = 1'b0;
                    w_next      = MEM_WAIT;
                end else begin
                    IFID_Flush = w_ctrl;
                    w_next     = RUN;
                end
            end
            MEM_WAIT: begin
                if (w_mw) begin
                    Pipe_Freeze = 1'b1;
                    PCWrite     = 1'b0;
                    IFIDWrite   = 1'b0;
                end else begin
                    w_next = RUN;
                end
            end
            default: w_next = RUN;
        endcase
        if (rst) begin
            PCWrite          = 1'b0;
            IFIDWrite        = 1'b0;
            Mux_Select_Stall = 1'b1;
            IFID_Flush       = 1'b0;
            Pipe_Freeze      = 1'b0;
        end
    end

    assign w_stall_inc = Mux_Select_Stall || Pipe_Freeze;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= RUN;
        else     r_state <= w_next;
    end

    // wait counter parks at its last value; the timeout flag is sticky anyway
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wait    <= '0;
            r_timeout <= 1'b0;
        end else if ((r_state == MEM_WAIT) && w_mw) begin
            if (r_wait == WAIT_LAST) r_timeout <= 1'b1;
            else                     r_wait    <= r_wait + 1'b1;
        end else begin
            r_wait <= '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else if (cnt_clear) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_stall_inc && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + 1'b1;
            if (IFID_Flush && (r_flush_cnt != '1))  r_flush_cnt <= r_flush_cnt + 1'b1;
        end
    end

    assign mem_timeout = r_timeout;
    assign stall_cnt   = r_stall_cnt;
    assign flush_cnt   = r_flush_cnt;

endmodule
